// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath:
// opcode/zero/step come in from the datapath side, mux selects and strobes go out.
interface multi_cycle_ctrl_if;
  logic        step;
  logic [5:0]  opcode;
  logic        zero;
  logic        pc_write;
  logic        pc_write_cond;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_source;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal;
  logic [15:0] instr_cnt;

  modport master (
    input  step, opcode, zero,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal, instr_cnt
  );

  modport slave (
    output step, opcode, zero,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal, instr_cnt
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath: decodes the IR opcode and
// steps FETCH/DECODE/execute states, free-running or gated by a single-step pulse.
module multi_cycle_ctrl #(
  parameter int MEM_LAT   = 1,
  parameter int STEP_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  multi_cycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RCOMPL = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        illegal_q, illegal_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  logic adv;
  logic last_wait;
  logic op_legal;
  logic instr_done;

  assign adv       = (STEP_MODE == 0) ? 1'b1 : bus.step;
  assign last_wait = (wait_q == LAST_WAIT);

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  end

  // An instruction retires on the advancing cycle of its last state; an illegal
  // opcode retires straight out of DECODE.
  always_comb begin
    instr_done = 1'b0;
    if (adv) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_RCOMPL, S_BRANCH, S_JUMP, S_ADDIWB: instr_done = 1'b1;
        S_DECODE: instr_done = !op_legal;
        default:  instr_done = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    illegal_d   = illegal_q;
    instr_cnt_d = instr_cnt_q;
    if (adv) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
          wait_d  = 3'd0;
        end
        S_FETCH: begin
          if (last_wait) state_d = S_DECODE;
          else           wait_d  = wait_q + 3'd1;
        end
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDIEX;
            default: begin
              state_d   = S_FETCH;
              wait_d    = 3'd0;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          if (bus.opcode == OP_LW) begin
            state_d = S_MEMRD;
            wait_d  = 3'd0;
          end else begin
            state_d = S_MEMWR;
          end
        end
        S_MEMRD: begin
          if (last_wait) state_d = S_MEMWB;
          else           wait_d  = wait_q + 3'd1;
        end
        S_EXEC:   state_d = S_RCOMPL;
        S_ADDIEX: state_d = S_ADDIWB;
        S_MEMWB, S_MEMWR, S_RCOMPL, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state_d = S_FETCH;
          wait_d  = 3'd0;
        end
        default: state_d = S_IDLE;
      endcase
      if (instr_done) instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_q      <= 3'd0;
      illegal_q   <= 1'b0;
      instr_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Selects decode from the registered state only; every write enable is also
  // qualified by adv so a stalled single-step never repeats a write.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = last_wait & adv;
        bus.pc_write  = last_wait & adv;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = adv;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = adv;
        bus.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_RCOMPL: begin
        bus.reg_write = adv;
        bus.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        bus.reg_write = adv;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_source     = 2'b01;
        bus.pc_write_cond = adv;
      end
      S_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = adv;
      end
      default: begin
        bus.pc_write = 1'b0;
      end
    endcase
  end

  assign bus.state      = state_q;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = illegal_q;
  assign bus.instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: a free-running MEM_LAT=1 instance and a
// single-stepped MEM_LAT=3 instance, both checked against an opcode-level model.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct packed {
    logic [3:0]  state;
    logic [15:0] instr_cnt;
    logic        instr_done;
    logic        illegal;
    logic        pc_write;
    logic        pc_write_cond;
    logic        mem_write;
    logic        reg_write;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        mem_to_reg;
    logic        reg_dst;
  } obs_t;

  logic        clk = 1'b0;
  logic        rstn [2];
  logic [5:0]  opc [2];
  logic        zro [2];
  logic        stp1;
  obs_t        obs [2];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          exp_q [2][$];
  int          retired [2];
  logic        active [2];
  logic [15:0] cnt_m [2];
  logic        ill_m [2];
  int          step_sel = 2;
  int          step_phase = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus0 ();
  multi_cycle_ctrl_if bus1 ();

  assign bus0.opcode = opc[0];
  assign bus0.zero   = zro[0];
  assign bus0.step   = 1'b0;
  assign bus1.opcode = opc[1];
  assign bus1.zero   = zro[1];
  assign bus1.step   = stp1;

  assign obs[0] = {bus0.state, bus0.instr_cnt, bus0.instr_done, bus0.illegal,
                   bus0.pc_write, bus0.pc_write_cond, bus0.mem_write, bus0.reg_write,
                   bus0.ir_write, bus0.i_or_d, bus0.mem_read, bus0.alu_src_a,
                   bus0.alu_src_b, bus0.alu_op, bus0.pc_source, bus0.mem_to_reg,
                   bus0.reg_dst};
  assign obs[1] = {bus1.state, bus1.instr_cnt, bus1.instr_done, bus1.illegal,
                   bus1.pc_write, bus1.pc_write_cond, bus1.mem_write, bus1.reg_write,
                   bus1.ir_write, bus1.i_or_d, bus1.mem_read, bus1.alu_src_a,
                   bus1.alu_src_b, bus1.alu_op, bus1.pc_source, bus1.mem_to_reg,
                   bus1.reg_dst};

  multi_cycle_ctrl #(.MEM_LAT(LAT0), .STEP_MODE(0)) dut0 (
    .clk (clk),
    .rst (rstn[0]),
    .bus (bus0)
  );

  multi_cycle_ctrl #(.MEM_LAT(LAT1), .STEP_MODE(1)) dut1 (
    .clk (clk),
    .rst (rstn[1]),
    .bus (bus1)
  );

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Selects {i_or_d, mem_read, alu_src_a, alu_src_b, alu_op, pc_source, mem_to_reg, reg_dst}
  function automatic logic [10:0] exp_sel(logic [3:0] st);
    case (st)
      4'd1:        return 11'b0_1_0_01_00_00_0_0;
      4'd2:        return 11'b0_0_0_11_00_00_0_0;
      4'd3, 4'd11: return 11'b0_0_1_10_00_00_0_0;
      4'd4:        return 11'b1_1_0_00_00_00_0_0;
      4'd5:        return 11'b0_0_0_00_00_00_1_0;
      4'd6:        return 11'b1_0_0_00_00_00_0_0;
      4'd7:        return 11'b0_0_1_00_10_00_0_0;
      4'd8:        return 11'b0_0_0_00_00_00_0_1;
      4'd9:        return 11'b0_0_1_00_01_01_0_0;
      4'd10:       return 11'b0_0_0_00_00_10_0_0;
      default:     return 11'd0;
    endcase
  endfunction

  // Expected-state entry: bits[3:0] state, [8] retiring state, [9] last fetch cycle, [10] illegal
  task automatic push(int d, int st, bit last, bit lf, bit ill);
    exp_q[d].push_back(st | (int'(last) << 8) | (int'(lf) << 9) | (int'(ill) << 10));
  endtask

  task automatic applyStimulus(int d, logic [5:0] op, logic z);
    int lat;
    lat = (d == 0) ? LAT0 : LAT1;
    opc[d] = op;
    zro[d] = z;
    for (int i = 0; i < lat; i++) push(d, 1, 1'b0, i == lat - 1, 1'b0);
    case (op)
      6'd0:  begin push(d, 2, 0, 0, 0); push(d, 7, 0, 0, 0); push(d, 8, 1, 0, 0); end
      6'd35: begin
        push(d, 2, 0, 0, 0); push(d, 3, 0, 0, 0);
        for (int i = 0; i < lat; i++) push(d, 4, 0, 0, 0);
        push(d, 5, 1, 0, 0);
      end
      6'd43: begin push(d, 2, 0, 0, 0); push(d, 3, 0, 0, 0); push(d, 6, 1, 0, 0); end
      6'd4:  begin push(d, 2, 0, 0, 0); push(d, 9, 1, 0, 0); end
      6'd2:  begin push(d, 2, 0, 0, 0); push(d, 10, 1, 0, 0); end
      6'd8:  begin push(d, 2, 0, 0, 0); push(d, 11, 0, 0, 0); push(d, 12, 1, 0, 0); end
      default: push(d, 2, 1, 0, 1);
    endcase
  endtask

  task automatic wait_retire(int d);
    int  start;
    bit  done;
    start = retired[d];
    done  = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      done = (retired[d] != start);
    end
    checkOutput($sformatf("dut%0d retire within budget", d), 32'(done), 32'd1);
    #1;
  endtask

  task automatic run(int d, logic [5:0] op, logic z);
    applyStimulus(d, op, z);
    wait_retire(d);
  endtask

  function automatic logic [5:0] rand_op();
    int k;
    int v;
    k = $urandom_range(0, 6);
    case (k)
      0: return 6'd0;
      1: return 6'd35;
      2: return 6'd43;
      3: return 6'd4;
      4: return 6'd2;
      5: return 6'd8;
      default: begin
        v = $urandom_range(0, 63);
        if (v == 0 || v == 35 || v == 43 || v == 4 || v == 2 || v == 8) v = 63;
        return 6'(v);
      end
    endcase
  endfunction

  task automatic monitor(int d);
    obs_t       o;
    int         e;
    logic       adv;
    logic [3:0] st;
    logic       last, lf, ill;
    logic [4:0] we_exp;
    o    = obs[d];
    e    = exp_q[d][0];
    st   = 4'(e & 15);
    last = e[8];
    lf   = e[9];
    ill  = e[10];
    adv  = (d == 0) ? 1'b1 : stp1;
    we_exp = {adv & (lf | (st == 4'd10)), adv & (st == 4'd9), adv & (st == 4'd6),
              adv & ((st == 4'd5) | (st == 4'd8) | (st == 4'd12)), adv & lf};
    checkOutput($sformatf("dut%0d state", d), 32'(o.state), 32'(st));
    checkOutput($sformatf("dut%0d selects st%0d", d, st),
                32'({o.i_or_d, o.mem_read, o.alu_src_a, o.alu_src_b, o.alu_op,
                     o.pc_source, o.mem_to_reg, o.reg_dst}), 32'(exp_sel(st)));
    checkOutput($sformatf("dut%0d write enables st%0d adv%0d", d, st, adv),
                32'({o.pc_write, o.pc_write_cond, o.mem_write, o.reg_write, o.ir_write}),
                32'(we_exp));
    checkOutput($sformatf("dut%0d instr_done", d), 32'(o.instr_done), 32'(adv & last));
    checkOutput($sformatf("dut%0d instr_cnt", d), 32'(o.instr_cnt), 32'(cnt_m[d]));
    checkOutput($sformatf("dut%0d illegal", d), 32'(o.illegal), 32'(ill_m[d]));
    if (adv) begin
      void'(exp_q[d].pop_front());
      if (last) begin
        cnt_m[d]   = cnt_m[d] + 16'd1;
        ill_m[d]   = ill_m[d] | ill;
        retired[d] = retired[d] + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (active[d] === 1'b1 && rstn[d] === 1'b1 && exp_q[d].size() > 0) monitor(d);
    end
  end

  always @(posedge clk) begin
    #1;
    if (step_sel == 0) begin
      stp1 = ($urandom_range(0, 2) == 0);
    end else if (step_sel == 1) begin
      step_phase = (step_phase + 1) % 5;
      stp1 = (step_phase == 0);
    end
  end

  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; opc[d] = 6'd0; zro[d] = 1'b0;
      active[d] = 1'b0; retired[d] = 0; cnt_m[d] = 16'd0; ill_m[d] = 1'b0;
    end
    stp1 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d reset state", d), 32'(obs[d].state), 32'd0);
      checkOutput($sformatf("dut%0d reset strobes", d),
                  32'({obs[d].pc_write, obs[d].pc_write_cond, obs[d].mem_write,
                       obs[d].reg_write, obs[d].ir_write, obs[d].mem_read, obs[d].instr_done}), 32'd0);
      checkOutput($sformatf("dut%0d reset cnt/illegal", d),
                  32'({obs[d].instr_cnt, obs[d].illegal}), 32'd0);
    end

    // Free-running instance: directed opcodes, then random ones.
    @(posedge clk); #1;
    push(0, 0, 0, 0, 0);
    applyStimulus(0, 6'd0, 1'b0);
    active[0] = 1'b1;
    rstn[0]   = 1'b1;
    wait_retire(0);
    run(0, 6'd35, 1'b0);
    run(0, 6'd43, 1'b0);
    run(0, 6'd4,  1'b1);
    run(0, 6'd4,  1'b0);
    run(0, 6'd2,  1'b0);
    run(0, 6'd8,  1'b0);
    run(0, 6'd63, 1'b0);
    run(0, 6'd0,  1'b0);
    for (int i = 0; i < 60; i++) run(0, rand_op(), 1'($urandom_range(0, 1)));
    active[0] = 1'b0;
    rstn[0]   = 1'b0;

    // Single-step instance: sw with a pulse every 5 clocks, then random steps.
    step_sel = 1;
    push(1, 0, 0, 0, 0);
    applyStimulus(1, 6'd43, 1'b0);
    active[1] = 1'b1;
    rstn[1]   = 1'b1;
    wait_retire(1);
    step_sel = 0;
    run(1, 6'd35, 1'b0);
    run(1, 6'd63, 1'b1);
    for (int i = 0; i < 30; i++) run(1, rand_op(), 1'($urandom_range(0, 1)));

    // Async reset in the middle of a stalled MEMWR.
    step_sel = 1;
    applyStimulus(1, 6'd43, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #2;
      found = (obs[1].state == 4'd6);
    end
    checkOutput("dut1 reached MEMWR", 32'(found), 32'd1);
    step_sel = 2;
    stp1 = 1'b1;
    #1;
    checkOutput("dut1 mem_write on step pulse", 32'(obs[1].mem_write), 32'd1);
    active[1] = 1'b0;
    rstn[1]   = 1'b0;
    #1;
    checkOutput("dut1 state after async reset", 32'(obs[1].state), 32'd0);
    checkOutput("dut1 mem_write after async reset", 32'(obs[1].mem_write), 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("dut1 strobes held in reset",
                  32'({obs[1].pc_write, obs[1].pc_write_cond, obs[1].mem_write,
                       obs[1].reg_write, obs[1].ir_write, obs[1].mem_read, obs[1].state}), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
